// File: rtl/transducer_pkg.sv
// Shared types and defaults for the transducer drive chain.
// Edge/duty/phase widths, channel count, and the preconditioner FSM states.
package transducer_pkg;
  localparam int DEF_WIDTH       = 13;
  localparam int DEF_DEPTH       = 249;
  localparam int PWM_PRE_LATENCY = 3;

  typedef logic [DEF_WIDTH-1:0]      edge_t;
  typedef logic signed [DEF_WIDTH:0] sedge_t;

  typedef enum logic [1:0] {IDLE, RUN, COMMIT} state_t;
endpackage

// File: rtl/pwm_edge_calc.sv
// Single-channel rise/fall edge pipeline: halves/full-on detect, raw add/sub, fold.
// Two register stages; the fold is combinational so the caller registers it into shadow.
module pwm_edge_calc
  import transducer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int IDXW  = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             vld_i,
  input  logic [IDXW-1:0]  idx_i,
  input  logic [WIDTH-1:0] cycle_i,
  input  logic [WIDTH-1:0] duty_i,
  input  logic [WIDTH-1:0] phase_i,
  output logic             vld_o,
  output logic [IDXW-1:0]  idx_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
);
  logic                    vld1_q, full1_q, zc1_q;
  logic [IDXW-1:0]         idx1_q;
  logic [WIDTH-1:0]        cyc1_q, ph1_q, lo1_q, hi1_q;
  logic                    vld2_q, full2_q, zc2_q;
  logic [IDXW-1:0]         idx2_q;
  logic [WIDTH-1:0]        cyc2_q;
  logic signed [WIDTH:0]   rr2_q, fr2_q;
  logic signed [WIDTH:0]   cyc_s;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld1_q  <= 1'b0;
      full1_q <= 1'b0;
      zc1_q   <= 1'b0;
      idx1_q  <= '0;
      cyc1_q  <= '0;
      ph1_q   <= '0;
      lo1_q   <= '0;
      hi1_q   <= '0;
      vld2_q  <= 1'b0;
      full2_q <= 1'b0;
      zc2_q   <= 1'b0;
      idx2_q  <= '0;
      cyc2_q  <= '0;
      rr2_q   <= '0;
      fr2_q   <= '0;
    end else begin
      vld1_q  <= vld_i;
      idx1_q  <= idx_i;
      cyc1_q  <= cycle_i;
      ph1_q   <= phase_i;
      lo1_q   <= duty_i >> 1;
      hi1_q   <= duty_i - (duty_i >> 1);
      full1_q <= (duty_i >= cycle_i);
      zc1_q   <= (cycle_i == '0);

      vld2_q  <= vld1_q;
      idx2_q  <= idx1_q;
      cyc2_q  <= cyc1_q;
      full2_q <= full1_q;
      zc2_q   <= zc1_q;
      rr2_q   <= $signed({1'b0, ph1_q}) - $signed({1'b0, lo1_q});
      fr2_q   <= $signed({1'b0, ph1_q}) + $signed({1'b0, hi1_q});
    end
  end

  // Each raw edge is folded back into [0, CYCLE) at most once.
  always_comb begin
    cyc_s  = $signed({1'b0, cyc2_q});
    rise_o = rr2_q[WIDTH] ? WIDTH'(rr2_q + cyc_s) : rr2_q[WIDTH-1:0];
    fall_o = (fr2_q >= cyc_s) ? WIDTH'(fr2_q - cyc_s) : fr2_q[WIDTH-1:0];
    if (zc2_q) begin
      rise_o = '0;
      fall_o = '0;
    end else if (full2_q) begin
      rise_o = '0;
      fall_o = cyc2_q;
    end
  end

  assign vld_o = vld2_q;
  assign idx_o = idx2_q;
endmodule

// File: rtl/pwm_preconditioner.sv
// Snapshots per-channel cycle/duty/phase on START, computes PWM edges one channel per clock,
// and publishes all RISE/FALL values together in a single commit clock with a DONE pulse.
module pwm_preconditioner
  import transducer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   START,
  input  logic [WIDTH*DEPTH-1:0] CYCLE,
  input  logic [WIDTH*DEPTH-1:0] DUTY,
  input  logic [WIDTH*DEPTH-1:0] PHASE,
  output logic [WIDTH*DEPTH-1:0] RISE,
  output logic [WIDTH*DEPTH-1:0] FALL,
  output logic                   BUSY,
  output logic                   DONE
);
  localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(DEPTH - 1);

  logic [WIDTH-1:0] cyc_in [DEPTH];
  logic [WIDTH-1:0] duty_in [DEPTH];
  logic [WIDTH-1:0] phase_in [DEPTH];
  logic [WIDTH-1:0] snap_cyc_q [DEPTH];
  logic [WIDTH-1:0] snap_duty_q [DEPTH];
  logic [WIDTH-1:0] snap_phase_q [DEPTH];
  logic [WIDTH-1:0] sh_rise_q [DEPTH];
  logic [WIDTH-1:0] sh_fall_q [DEPTH];
  logic [WIDTH-1:0] rise_q [DEPTH];
  logic [WIDTH-1:0] fall_q [DEPTH];

  state_t           state_q;
  logic [IDXW-1:0]  cnt_q;
  logic             issue_q, last_q, busy_q, done_q;
  logic             pe_vld;
  logic [IDXW-1:0]  pe_idx;
  logic [WIDTH-1:0] pe_rise, pe_fall;

  for (genvar g = 0; g < DEPTH; g++) begin : g_ch
    assign cyc_in[g]                  = CYCLE[g*WIDTH +: WIDTH];
    assign duty_in[g]                 = DUTY[g*WIDTH +: WIDTH];
    assign phase_in[g]                = PHASE[g*WIDTH +: WIDTH];
    assign RISE[g*WIDTH +: WIDTH]     = rise_q[g];
    assign FALL[g*WIDTH +: WIDTH]     = fall_q[g];
  end

  pwm_edge_calc #(.WIDTH(WIDTH), .IDXW(IDXW)) u_calc (
    .clk_i   (CLK),
    .rst_ni  (RST_N),
    .vld_i   (issue_q),
    .idx_i   (cnt_q),
    .cycle_i (snap_cyc_q[cnt_q]),
    .duty_i  (snap_duty_q[cnt_q]),
    .phase_i (snap_phase_q[cnt_q]),
    .vld_o   (pe_vld),
    .idx_o   (pe_idx),
    .rise_o  (pe_rise),
    .fall_o  (pe_fall)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      issue_q      <= 1'b0;
      last_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      snap_cyc_q   <= '{default: '0};
      snap_duty_q  <= '{default: '0};
      snap_phase_q <= '{default: '0};
      sh_rise_q    <= '{default: '0};
      sh_fall_q    <= '{default: '0};
      rise_q       <= '{default: '0};
      fall_q       <= '{default: '0};
    end else begin
      done_q <= 1'b0;
      if (pe_vld) begin
        sh_rise_q[pe_idx] <= pe_rise;
        sh_fall_q[pe_idx] <= pe_fall;
        if (pe_idx == LAST) last_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (START) begin
            snap_cyc_q   <= cyc_in;
            snap_duty_q  <= duty_in;
            snap_phase_q <= phase_in;
            cnt_q        <= '0;
            issue_q      <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= RUN;
          end
        end
        RUN: begin
          if (issue_q) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST) issue_q <= 1'b0;
          end
          // Commit happens on the transition so DONE is high while still in COMMIT.
          if (last_q) begin
            rise_q  <= sh_rise_q;
            fall_q  <= sh_fall_q;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            last_q  <= 1'b0;
            state_q <= COMMIT;
          end
        end
        COMMIT:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign BUSY = busy_q;
  assign DONE = done_q;
endmodule

// File: tb/tb_pwm_preconditioner.sv
// Directed bench for pwm_preconditioner: edge arithmetic, special cases, atomic commit,
// START filtering and asynchronous mid-pass reset.
module tb_pwm_preconditioner;
  localparam int W = 13;
  localparam int D = 249;
  localparam int N = W * D;

  logic         CLK = 1'b0;
  logic         RST_N = 1'b0;
  logic         START = 1'b0;
  logic [N-1:0] CYCLE, DUTY, PHASE;
  logic [N-1:0] RISE, FALL;
  logic         BUSY, DONE;

  int n_checks = 0;
  int n_fail = 0;
  int done_cyc, busy_cnt, changed;

  pwm_preconditioner dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .START (START),
    .CYCLE (CYCLE),
    .DUTY  (DUTY),
    .PHASE (PHASE),
    .RISE  (RISE),
    .FALL  (FALL),
    .BUSY  (BUSY),
    .DONE  (DONE)
  );

  always #5 CLK = ~CLK;

  task automatic set_ch(input int i, input int c, input int d, input int p);
    CYCLE[i*W +: W] = W'(c);
    DUTY[i*W +: W]  = W'(d);
    PHASE[i*W +: W] = W'(p);
  endtask

  function automatic int rise_of(input int i);
    return int'(RISE[i*W +: W]);
  endfunction

  function automatic int fall_of(input int i);
    return int'(FALL[i*W +: W]);
  endfunction

  function automatic void model(input int c, input int d, input int p, output int r, output int f);
    int lo, hi;
    if (c == 0) begin
      r = 0; f = 0;
    end else if (d >= c) begin
      r = 0; f = c;
    end else begin
      lo = d / 2;
      hi = d - lo;
      r = p - lo;
      if (r < 0) r += c;
      f = p + hi;
      if (f >= c) f -= c;
    end
  endfunction

  // Called at posedge+1; pulses START now (cycle 0) and returns at DONE cycle + 1.
  task automatic run_pass(input bit extra, input bit scramble);
    int cyc;
    logic [N-1:0] r0, f0;
    r0 = RISE; f0 = FALL;
    done_cyc = -1; busy_cnt = 0; changed = 0;
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    cyc = 1;
    while (cyc < 400) begin
      if (DONE === 1'b1) begin
        done_cyc = cyc;
        if (extra) START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        break;
      end
      if (BUSY === 1'b1) busy_cnt++;
      if (RISE !== r0 || FALL !== f0) changed = 1;
      START = (extra && cyc == 10);
      if (scramble && cyc == 2)
        for (int i = 0; i < D; i++) set_ch(i, 1000, 999, 7);
      @(posedge CLK); #1;
      cyc++;
    end
  endtask

  task automatic test_reset;
    CYCLE = '0; DUTY = '0; PHASE = '0;
    RST_N = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    n_checks++; if (RISE !== '0) begin n_fail++; $display("FAIL reset_rise: got nonzero, expected 0"); end
    n_checks++; if (FALL !== '0) begin n_fail++; $display("FAIL reset_fall: got nonzero, expected 0"); end
    n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", BUSY); end
    n_checks++; if (DONE !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b, expected 0", DONE); end
    @(negedge CLK); RST_N = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic test_half_duty;
    int bad, first;
    for (int i = 0; i < D; i++) set_ch(i, 4096, 2048, 0);
    run_pass(1'b0, 1'b0);
    n_checks++; if (done_cyc !== 253) begin n_fail++; $display("FAIL half_done_cycle: got %0d, expected 253", done_cyc); end
    n_checks++; if (busy_cnt !== 252) begin n_fail++; $display("FAIL half_busy_clocks: got %0d, expected 252", busy_cnt); end
    n_checks++; if (changed !== 0) begin n_fail++; $display("FAIL half_outputs_early: got change before DONE, expected none"); end
    n_checks++; if (DONE !== 1'b0 || BUSY !== 1'b0) begin n_fail++; $display("FAIL half_after_done: got DONE=%b BUSY=%b, expected 0 0", DONE, BUSY); end
    bad = 0; first = -1;
    for (int i = 0; i < D; i++)
      if (rise_of(i) !== 3072 || fall_of(i) !== 1024) begin bad++; if (first < 0) first = i; end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL half_values: %0d channels wrong, ch %0d got %0d/%0d, expected 3072/1024",
               bad, first, rise_of(first), fall_of(first));
    end
  endtask

  task automatic test_wrap;
    int bad, first, er, ef;
    for (int i = 0; i < D; i++) set_ch(i, 4096, 5, (i % 2 == 1) ? 1 : 4094);
    run_pass(1'b0, 1'b0);
    n_checks++; if (done_cyc !== 253) begin n_fail++; $display("FAIL wrap_done_cycle: got %0d, expected 253", done_cyc); end
    bad = 0; first = -1;
    for (int i = 0; i < D; i++) begin
      er = (i % 2 == 1) ? 4095 : 4092;
      ef = (i % 2 == 1) ? 4 : 1;
      if (rise_of(i) !== er || fall_of(i) !== ef) begin bad++; if (first < 0) first = i; end
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL wrap_values: %0d channels wrong, ch %0d got %0d/%0d", bad, first, rise_of(first), fall_of(first));
    end
  endtask

  task automatic test_special;
    int bad, first, g;
    int er[4] = '{100, 0, 0, 0};
    int ef[4] = '{100, 4096, 4096, 0};
    for (int i = 0; i < D; i++) begin
      case (i % 4)
        0:       set_ch(i, 4096, 0, 100);
        1:       set_ch(i, 4096, 4096, 300);
        2:       set_ch(i, 4096, 5000, 300);
        default: set_ch(i, 0, 10, 0);
      endcase
    end
    run_pass(1'b0, 1'b0);
    n_checks++; if (done_cyc !== 253) begin n_fail++; $display("FAIL special_done_cycle: got %0d, expected 253", done_cyc); end
    bad = 0; first = -1;
    for (int i = 0; i < D; i++) begin
      g = i % 4;
      if (rise_of(i) !== er[g] || fall_of(i) !== ef[g]) begin bad++; if (first < 0) first = i; end
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL special_values: %0d channels wrong, ch %0d got %0d/%0d, expected %0d/%0d",
               bad, first, rise_of(first), fall_of(first), er[first % 4], ef[first % 4]);
    end
  endtask

  task automatic test_distinct;
    int bad, first, er, ef;
    for (int i = 0; i < D; i++) set_ch(i, 4096, i * 8, i * 16);
    run_pass(1'b0, 1'b1);
    n_checks++; if (done_cyc !== 253) begin n_fail++; $display("FAIL distinct_done_cycle: got %0d, expected 253", done_cyc); end
    n_checks++; if (changed !== 0) begin n_fail++; $display("FAIL distinct_mid_pass: got outputs changing before DONE, expected stable"); end
    bad = 0; first = -1;
    for (int i = 0; i < D; i++) begin
      model(4096, i * 8, i * 16, er, ef);
      if (rise_of(i) !== er || fall_of(i) !== ef) begin bad++; if (first < 0) first = i; end
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL distinct_values: %0d channels wrong, first ch %0d got %0d/%0d", bad, first, rise_of(first), fall_of(first));
    end
  endtask

  task automatic test_start_ignore;
    int bad;
    for (int i = 0; i < D; i++) set_ch(i, 3000, 100, 50);
    run_pass(1'b1, 1'b0);
    n_checks++; if (done_cyc !== 253) begin n_fail++; $display("FAIL ignore_done_cycle: got %0d, expected 253", done_cyc); end
    n_checks++; if (busy_cnt !== 252) begin n_fail++; $display("FAIL ignore_busy_clocks: got %0d, expected 252", busy_cnt); end
    n_checks++; if (DONE !== 1'b0 || BUSY !== 1'b0) begin n_fail++; $display("FAIL ignore_clock254: got DONE=%b BUSY=%b, expected 0 0", DONE, BUSY); end
    bad = 0;
    for (int i = 0; i < D; i++) if (rise_of(i) !== 0 || fall_of(i) !== 100) bad++;
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL ignore_values: got %0d wrong channels, expected 0", bad); end
    for (int i = 0; i < D; i++) set_ch(i, 3000, 200, 10);
    run_pass(1'b0, 1'b0);
    n_checks++; if (done_cyc !== 253) begin n_fail++; $display("FAIL restart254_done_cycle: got %0d, expected 253", done_cyc); end
    bad = 0;
    for (int i = 0; i < D; i++) if (rise_of(i) !== 2910 || fall_of(i) !== 110) bad++;
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL restart254_values: got %0d wrong channels, expected 0", bad); end
  endtask

  task automatic test_reset_mid;
    int dones, busys, bad, er, ef;
    for (int i = 0; i < D; i++) set_ch(i, 4096, i * 8, i * 16);
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (99) @(posedge CLK);
    #1;
    n_checks++; if (BUSY !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_before: got %b, expected 1", BUSY); end
    RST_N = 1'b0;
    #1;
    n_checks++; if (RISE !== '0) begin n_fail++; $display("FAIL midrst_rise: got nonzero, expected 0"); end
    n_checks++; if (FALL !== '0) begin n_fail++; $display("FAIL midrst_fall: got nonzero, expected 0"); end
    n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b, expected 0", BUSY); end
    n_checks++; if (DONE !== 1'b0) begin n_fail++; $display("FAIL midrst_done: got %b, expected 0", DONE); end
    @(negedge CLK); RST_N = 1'b1;
    @(posedge CLK); #1;
    dones = 0; busys = 0;
    for (int c = 0; c < 300; c++) begin
      if (DONE !== 1'b0) dones++;
      if (BUSY !== 1'b0) busys++;
      @(posedge CLK); #1;
    end
    n_checks++; if (dones != 0) begin n_fail++; $display("FAIL midrst_stray_done: got %0d DONE clocks, expected 0", dones); end
    n_checks++; if (busys != 0) begin n_fail++; $display("FAIL midrst_stray_busy: got %0d BUSY clocks, expected 0", busys); end
    run_pass(1'b0, 1'b0);
    n_checks++; if (done_cyc !== 253) begin n_fail++; $display("FAIL midrst_fresh_done: got %0d, expected 253", done_cyc); end
    bad = 0;
    for (int i = 0; i < D; i++) begin
      model(4096, i * 8, i * 16, er, ef);
      if (rise_of(i) !== er || fall_of(i) !== ef) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL midrst_fresh_values: got %0d wrong channels, expected 0", bad); end
  endtask

  initial begin
    test_reset();
    test_half_duty();
    test_wrap();
    test_special();
    test_distinct();
    test_start_ignore();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
